// File: rtl/saes_pkg.sv
// saes_pkg: S-AES constants, nibble/byte helpers and FSM state type
package saes_pkg;
  localparam logic [0:15][3:0] SBOX = {4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
                                       4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
  localparam logic [7:0] RCON1 = 8'h80;
  localparam logic [7:0] RCON2 = 8'h30;
  typedef enum logic [1:0] {IDLE, R1, R2, DONE} state_e;
  function automatic logic [7:0] sub_nib8(input logic [7:0] b);
    return {SBOX[b[7:4]], SBOX[b[3:0]]};
  endfunction
  function automatic logic [15:0] sub_nib16(input logic [15:0] s);
    return {sub_nib8(s[15:8]), sub_nib8(s[7:0])};
  endfunction
  function automatic logic [7:0] rot_nib(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction
  function automatic logic [15:0] shift_rows(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction
  // multiply by x^2 in GF(2^4) mod x^4+x+1: two reduced left shifts
  function automatic logic [3:0] gf16_mul4(input logic [3:0] a);
    logic [3:0] t;
    t = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    return {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
  endfunction
  function automatic logic [15:0] mix_col(input logic [15:0] s);
    return {s[15:12] ^ gf16_mul4(s[11:8]), gf16_mul4(s[15:12]) ^ s[11:8],
            s[7:4] ^ gf16_mul4(s[3:0]), gf16_mul4(s[7:4]) ^ s[3:0]};
  endfunction
endpackage

// File: rtl/saes_encrypt_iter_if.sv
// saes_encrypt_iter_if: valid/ready plaintext-in and ciphertext-out bus
interface saes_encrypt_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] codein;
  logic [15:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] codeout;
  modport master (output in_valid, codein, key, out_ready, input in_ready, out_valid, codeout);
  modport slave (input in_valid, codein, key, out_ready, output in_ready, out_valid, codeout);
endinterface

// File: rtl/saes_key_expand.sv
// saes_key_expand: combinational S-AES round-key expansion, key -> K1, K2
module saes_key_expand
  import saes_pkg::*;
(
  input  logic [15:0] key,
  output logic [15:0] k1,
  output logic [15:0] k2
);
  logic [7:0] w2, w3, w4;
  assign w2 = key[15:8] ^ RCON1 ^ sub_nib8(rot_nib(key[7:0]));
  assign w3 = w2 ^ key[7:0];
  assign w4 = w2 ^ RCON2 ^ sub_nib8(rot_nib(w3));
  assign k1 = {w2, w3};
  assign k2 = {w4, w4 ^ w3};
endmodule

// File: rtl/saes_encrypt_iter.sv
// saes_encrypt_iter: iterative S-AES encryptor, one round per clock
module saes_encrypt_iter
  import saes_pkg::*;
#(
  parameter bit HOLD_OUTPUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  saes_encrypt_iter_if.slave bus,
  output logic busy
);
  state_e      state_q, state_d;
  logic [15:0] st_q, st_d, k1_q, k1_d, k2_q, k2_d, codeout_q, codeout_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] k1_w, k2_w;
  logic        accept;
  saes_key_expand u_key_expand (.key(bus.key), .k1(k1_w), .k2(k2_w));
  assign bus.in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
  assign bus.out_valid = out_valid_q;
  assign bus.codeout   = codeout_q;
  assign busy          = (state_q == R1) | (state_q == R2);
  assign accept        = bus.in_valid & bus.in_ready;
  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    codeout_d   = codeout_q;
    out_valid_d = out_valid_q;
    case (state_q)
      R1: begin
        st_d    = mix_col(shift_rows(sub_nib16(st_q))) ^ k1_q;
        state_d = R2;
      end
      R2: begin
        codeout_d   = shift_rows(sub_nib16(st_q)) ^ k2_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        codeout_d   = HOLD_OUTPUT ? codeout_q : 16'h0000;
        state_d     = IDLE;
      end
      default: ;
    endcase
    // a new block can be loaded from IDLE or on the DONE output handshake
    if (accept) begin
      st_d    = bus.codein ^ bus.key;
      k1_d    = k1_w;
      k2_d    = k2_w;
      state_d = R1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      st_q        <= '0;
      k1_q        <= '0;
      k2_q        <= '0;
      codeout_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      codeout_q   <= codeout_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_saes_encrypt_iter.sv
// tb_saes_encrypt_iter: directed S-AES vectors on HOLD_OUTPUT=1 and =0 builds
module tb_saes_encrypt_iter;
  logic clk = 1'b0;
  logic rst;
  logic busy_h, busy_z;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  saes_encrypt_iter_if ifh ();
  saes_encrypt_iter_if ifz ();
  saes_encrypt_iter #(.HOLD_OUTPUT(1'b1)) dut_h (.clk(clk), .rst(rst), .bus(ifh), .busy(busy_h));
  saes_encrypt_iter #(.HOLD_OUTPUT(1'b0)) dut_z (.clk(clk), .rst(rst), .bus(ifz), .busy(busy_z));
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic iv, input logic [15:0] ci, input logic [15:0] k, input logic ordy);
    ifh.in_valid = iv; ifh.codein = ci; ifh.key = k; ifh.out_ready = ordy;
    ifz.in_valid = iv; ifz.codein = ci; ifz.key = k; ifz.out_ready = ordy;
  endtask
  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    #12;
    chk("rst_in_ready", ifh.in_ready, 0);
    chk("rst_out_valid", ifh.out_valid, 0);
    chk("rst_busy", busy_h, 0);
    chk("rst_codeout", ifh.codeout, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", ifh.in_ready, 1);
    // vector 1 with busy-time input noise
    drive(1'b1, 16'h6F6B, 16'hA73B, 1'b0);
    @(negedge clk);
    chk("r1_busy", busy_h, 1);
    chk("r1_in_ready", ifh.in_ready, 0);
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b0);
    @(negedge clk);
    chk("r2_out_valid", ifh.out_valid, 0);
    drive(1'b1, 16'h1234, 16'h5555, 1'b0);
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("v1_out_valid", ifh.out_valid, 1);
    chk("v1_codeout", ifh.codeout, 16'h0738);
    chk("v1_busy", busy_h, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", ifh.out_valid, 1);
      chk("bp_codeout", ifh.codeout, 16'h0738);
      chk("bp_in_ready", ifh.in_ready, 0);
    end
    // handshake and accept vector 2 on the same edge
    drive(1'b1, 16'hD728, 16'h4AF5, 1'b1);
    #1;
    chk("done_in_ready", ifh.in_ready, 1);
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("v2_r1_out_valid", ifh.out_valid, 0);
    chk("v2_r1_busy", busy_h, 1);
    chk("hold1_codeout", ifh.codeout, 16'h0738);
    chk("hold0_codeout", ifz.codeout, 16'h0000);
    @(negedge clk);
    chk("v2_r2_out_valid", ifh.out_valid, 0);
    @(negedge clk);
    chk("v2_out_valid", ifh.out_valid, 1);
    chk("v2_codeout", ifh.codeout, 16'h24EC);
    chk("v2_codeout_z", ifz.codeout, 16'h24EC);
    @(negedge clk);
    chk("v2_hs_out_valid", ifh.out_valid, 0);
    chk("v2_hs_in_ready", ifh.in_ready, 1);
    chk("v2_hold1", ifh.codeout, 16'h24EC);
    chk("v2_hold0", ifz.codeout, 16'h0000);
    // reset in R2
    drive(1'b1, 16'h6F6B, 16'hA73B, 1'b0);
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    chk("pre_rst_busy", busy_h, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", ifh.out_valid, 0);
    chk("mid_rst_codeout", ifh.codeout, 16'h0000);
    chk("mid_rst_busy", busy_h, 0);
    chk("mid_rst_in_ready", ifh.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", ifh.in_ready, 1);
    drive(1'b1, 16'h6F6B, 16'hA73B, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 10 && !ifh.out_valid; i++) @(negedge clk);
    chk("v3_out_valid", ifh.out_valid, 1);
    chk("v3_codeout", ifh.codeout, 16'h0738);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
